flag_map_ctrl: RTL



---
 rtl/flag_map_pkg.sv | 46 ++++
 rtl/flag_req_check.sv | 36 +++
 rtl/flag_map_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/flag_map_pkg.sv
// Shared types and helpers for the flag-map controller: FSM states, level
// encodings, default board sizes and the level-to-edge-length lookup.
package flag_map_pkg;

  localparam int unsigned DEF_DIM_EASY   = 8;
  localparam int unsigned DEF_DIM_MEDIUM = 10;
  localparam int unsigned DEF_DIM_HARD   = 16;
  localparam int unsigned DEF_IDX_W      = 5;
  localparam int unsigned DEF_CNT_W      = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_CLEAR = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    LVL_NONE   = 2'd0,
    LVL_EASY   = 2'd1,
    LVL_MEDIUM = 2'd2,
    LVL_HARD   = 2'd3
  } level_e;

  // One bit per refusal cause; all-zero means the request is legal.
  typedef struct packed {
    logic no_game;
    logic out_of_range;
    logic revealed;
    logic cap_full;
  } reject_t;

  function automatic int unsigned dim_of(input logic [1:0]  lvl,
                                         input int unsigned d_easy,
                                         input int unsigned d_medium,
                                         input int unsigned d_hard);
    int unsigned d;
    case (level_e'(lvl))
      LVL_EASY:   d = d_easy;
      LVL_MEDIUM: d = d_medium;
      LVL_HARD:   d = d_hard;
      default:    d = 0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/flag_req_check.sv
// Combinational legality check for a captured flag toggle request.
module flag_req_check
  import flag_map_pkg::*;
#(
  parameter int unsigned DIM_EASY   = DEF_DIM_EASY,
  parameter int unsigned DIM_MEDIUM = DEF_DIM_MEDIUM,
  parameter int unsigned DIM_HARD   = DEF_DIM_HARD,
  parameter int unsigned IDX_W      = DEF_IDX_W,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic [1:0]       level,
  input  logic [IDX_W-1:0] x,
  input  logic [IDX_W-1:0] y,
  input  logic             revealed,
  input  logic             cell_flagged,
  input  logic [CNT_W-1:0] flag_num,
  input  logic [CNT_W-1:0] mine_num,
  output logic             valid_c,
  output reject_t          reason_c
);

  logic [31:0] dim_c;

  always_comb begin
    dim_c                 = 32'(dim_of(level, DIM_EASY, DIM_MEDIUM, DIM_HARD));
    reason_c              = '0;
    reason_c.no_game      = (level == LVL_NONE);
    reason_c.out_of_range = (x == '0) || (y == '0) ||
                            (32'(x) > dim_c) || (32'(y) > dim_c);
    reason_c.revealed     = revealed;
    // Removing a flag is always allowed; only placing one is capped.
    reason_c.cap_full     = !cell_flagged && (flag_num >= mine_num);
    valid_c               = (reason_c == '0);
  end

endmodule

// File: rtl/flag_map_ctrl.sv
// Flag map controller: holds the flag array and counter, applies validated
// toggle requests with ack/reject pulses and sweeps the map clear on restart.
module flag_map_ctrl
  import flag_map_pkg::*;
#(
  parameter int unsigned DIM_EASY   = DEF_DIM_EASY,
  parameter int unsigned DIM_MEDIUM = DEF_DIM_MEDIUM,
  parameter int unsigned DIM_HARD   = DEF_DIM_HARD,
  parameter int unsigned IDX_W      = DEF_IDX_W,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [1:0]                         level,
  input  logic                               clear_req,
  input  logic                               mark_flag,
  input  logic [IDX_W-1:0]                   flag_ind_x,
  input  logic [IDX_W-1:0]                   flag_ind_y,
  input  logic                               cell_revealed,
  input  logic [CNT_W-1:0]                   mine_num,
  output logic [DIM_HARD-1:0][DIM_HARD-1:0]  flag_arr,
  output logic [CNT_W-1:0]                   flag_num,
  output logic                               busy,
  output logic                               flag_ack,
  output logic                               flag_reject,
  output logic                               all_used
);

  localparam int unsigned AW = (DIM_HARD > 1) ? $clog2(DIM_HARD) : 1;

  state_e                            state_q, state_d;
  logic [AW-1:0]                     row_q, row_d;
  logic [DIM_HARD-1:0][DIM_HARD-1:0] flag_arr_q, flag_arr_d;
  logic [CNT_W-1:0]                  flag_num_q, flag_num_d;
  logic [IDX_W-1:0]                  req_x_q, req_x_d, req_y_q, req_y_d;
  logic                              req_rev_q, req_rev_d;
  logic [1:0]                        level_prev_q, level_prev_d;
  logic                              busy_q, busy_d;
  logic                              ack_q, ack_d, rej_q, rej_d;

  logic [AW-1:0] xi_c, yi_c;
  logic          cell_flagged_c;
  logic          clear_trig_c;
  logic          req_valid_c;
  reject_t       req_reason_c;

  // Indices are 1-based on the port; in-range values map onto the array.
  assign xi_c           = AW'(req_x_q - IDX_W'(1));
  assign yi_c           = AW'(req_y_q - IDX_W'(1));
  assign cell_flagged_c = flag_arr_q[xi_c][yi_c];
  assign clear_trig_c   = clear_req || (level != level_prev_q);

  flag_req_check #(
    .DIM_EASY   (DIM_EASY),
    .DIM_MEDIUM (DIM_MEDIUM),
    .DIM_HARD   (DIM_HARD),
    .IDX_W      (IDX_W),
    .CNT_W      (CNT_W)
  ) u_req_check (
    .level        (level),
    .x            (req_x_q),
    .y            (req_y_q),
    .revealed     (req_rev_q),
    .cell_flagged (cell_flagged_c),
    .flag_num     (flag_num_q),
    .mine_num     (mine_num),
    .valid_c      (req_valid_c),
    .reason_c     (req_reason_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      flag_arr_q   <= '0;
      flag_num_q   <= '0;
      req_x_q      <= '0;
      req_y_q      <= '0;
      req_rev_q    <= 1'b0;
      level_prev_q <= 2'(LVL_NONE);
      busy_q       <= 1'b0;
      ack_q        <= 1'b0;
      rej_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      flag_arr_q   <= flag_arr_d;
      flag_num_q   <= flag_num_d;
      req_x_q      <= req_x_d;
      req_y_q      <= req_y_d;
      req_rev_q    <= req_rev_d;
      level_prev_q <= level_prev_d;
      busy_q       <= busy_d;
      ack_q        <= ack_d;
      rej_q        <= rej_d;
    end
  end

  // Clear trigger pre-empts everything, including a captured request.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    flag_arr_d   = flag_arr_q;
    flag_num_d   = flag_num_q;
    req_x_d      = req_x_q;
    req_y_d      = req_y_q;
    req_rev_d    = req_rev_q;
    level_prev_d = level;
    ack_d        = 1'b0;
    rej_d        = 1'b0;

    if (clear_trig_c) begin
      state_d    = S_CLEAR;
      row_d      = '0;
      flag_num_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mark_flag) begin
            req_x_d   = flag_ind_x;
            req_y_d   = flag_ind_y;
            req_rev_d = cell_revealed;
            state_d   = S_APPLY;
          end
        end
        S_APPLY: begin
          state_d = S_IDLE;
          ack_d   = req_valid_c;
          rej_d   = |req_reason_c;
          if (req_valid_c) begin
            flag_arr_d[xi_c][yi_c] = !cell_flagged_c;
            if (cell_flagged_c) begin
              if (flag_num_q != '0) flag_num_d = flag_num_q - CNT_W'(1);
            end else begin
              if (flag_num_q != '1) flag_num_d = flag_num_q + CNT_W'(1);
            end
          end
        end
        S_CLEAR: begin
          flag_arr_d[row_q] = '0;
          if (row_q == AW'(DIM_HARD - 1)) begin
            state_d = S_IDLE;
          end else begin
            row_d = row_q + AW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  assign flag_arr    = flag_arr_q;
  assign flag_num    = flag_num_q;
  assign busy        = busy_q;
  assign flag_ack    = ack_q;
  assign flag_reject = rej_q;
  assign all_used    = (flag_num_q == mine_num);

endmodule
